// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// Builds each 32-bit little-endian instruction from four reads of a byte-wide
// synchronous memory port. The word is held for decode until it is accepted,
// and fetching is redirected whenever a branch/jump arrives from EX.
// Optional direct-mapped instruction cache, enabled by defining ICACHE_EN.
// Valid/ready: inst_valid_o stays high with pc_o/inst_o stable until a cycle where
// id_ready_i=1 and stall_i=0; that cycle is the transfer. branch_i overrides it.
module inst_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_a_o,
    output logic        mem_req_o,
    input  logic [7:0]  mem_din_i,
    input  logic        stall_i,
    input  logic        id_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]  state;
    logic [2:0]  cnt;
    logic [23:0] byte_buf;
    logic        accept;
    logic [31:0] word;
    logic        fill_en;
    logic        cache_hit;
    logic [31:0] cache_word;

    assign accept  = inst_valid_o & id_ready_i & ~stall_i;
    // The last byte arrives on the same edge that publishes the word.
    assign word    = {mem_din_i, byte_buf};
    assign fill_en = ~branch_i & (state == ST_FETCH) & (cnt == 3'd4);

`ifdef ICACHE_EN
    localparam int IW = $clog2(ICACHE_LINES);
    localparam int TW = 30 - IW;

    logic [ICACHE_LINES-1:0] line_valid;
    logic [TW-1:0]           line_tag  [ICACHE_LINES];
    logic [31:0]             line_data [ICACHE_LINES];
    logic [IW-1:0]           idx;
    logic [TW-1:0]           tag;

    assign idx        = pc_o[IW+1:2];
    assign tag        = pc_o[31:IW+2];
    assign cache_hit  = line_valid[idx] & (line_tag[idx] == tag);
    assign cache_word = line_data[idx];

    // Line valid bits: set when a fill completes, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid <= '0;
        end else if (fill_en) begin
            line_valid[idx] <= 1'b1;
        end
    end

    // Line tag/data storage: written with the assembled word on the final fill edge.
    always_ff @(posedge clk) begin
        if (rst && fill_en) begin
            line_tag[idx]  <= tag;
            line_data[idx] <= word;
        end
    end
`else
    // No storage: never hits. The comparison only keeps the shared parameter referenced.
    assign cache_hit  = (ICACHE_LINES < 0);
    assign cache_word = 32'h0;
`endif

    // Fetch sequencer: byte requests, word assembly, hold for decode, branch redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_FETCH;
            cnt          <= 3'd0;
            byte_buf     <= 24'h0;
            pc_o         <= RESET_PC;
            inst_o       <= 32'h0;
            inst_valid_o <= 1'b0;
            mem_a_o      <= 32'h0;
            mem_req_o    <= 1'b0;
        end else if (branch_i) begin
            // Redirect wins over everything, including a same-cycle accept.
            pc_o         <= branch_target_i;
            inst_valid_o <= 1'b0;
            cnt          <= 3'd0;
            state        <= ST_FETCH;
            mem_req_o    <= 1'b0;
        end else if (state == ST_HOLD) begin
            if (accept) begin
                pc_o         <= pc_o + 32'd4;
                inst_valid_o <= 1'b0;
                cnt          <= 3'd0;
                state        <= ST_FETCH;
            end
        end else if ((cnt == 3'd0) && cache_hit) begin
            inst_o       <= cache_word;
            inst_valid_o <= 1'b1;
            state        <= ST_HOLD;
        end else begin
            case (cnt)
                3'd1:    byte_buf[7:0]   <= mem_din_i;
                3'd2:    byte_buf[15:8]  <= mem_din_i;
                3'd3:    byte_buf[23:16] <= mem_din_i;
                default: byte_buf        <= byte_buf;
            endcase
            if (cnt == 3'd4) begin
                mem_req_o    <= 1'b0;
                inst_o       <= word;
                inst_valid_o <= 1'b1;
                state        <= ST_HOLD;
                cnt          <= 3'd0;
            end else begin
                mem_req_o <= 1'b1;
                mem_a_o   <= pc_o + {29'b0, cnt};
                cnt       <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a fetch-timeline reference model.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          LINES    = 16;
`ifdef ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_a_o;
    logic        mem_req_o;
    logic [7:0]  mem_din_i;
    logic        stall_i = 1'b0;
    logic        id_ready_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    logic [7:0]  mem [512];
    int          n_checks = 0;
    int          n_fail = 0;

    inst_fetch #(.RESET_PC(RESET_PC), .ICACHE_LINES(LINES)) dut (
        .clk(clk), .rst(rst),
        .mem_a_o(mem_a_o), .mem_req_o(mem_req_o), .mem_din_i(mem_din_i),
        .stall_i(stall_i), .id_ready_i(id_ready_i),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory: the byte for the address issued on the previous edge is on mem_din_i now.
    assign mem_din_i = mem[mem_a_o[8:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] ai;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ai = a + 32'(i);
            w[8*i +: 8] = mem[ai[8:0]];
        end
        return w;
    endfunction

    // ---------------- reference model ----------------
    // m_t = edges since the current fetch began; a memory fetch issues bytes on
    // edges 1..4 and shows the word after edge 5; a cache hit shows it after edge 1.
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_a = 32'h0;
    int          m_t = 0;
    bit          m_hit = 1'b0;
    bit          c_valid [LINES];
    logic [31:0] c_pc    [LINES];
    logic [31:0] c_word  [LINES];

    function automatic bit m_valid_now();
        return m_hit ? (m_t >= 1) : (m_t >= 5);
    endfunction

    function automatic bit cache_has(input logic [31:0] a);
        int i;
        i = int'(a[5:2]);
        return CACHE_ON && c_valid[i] && (c_pc[i][31:2] == a[31:2]);
    endfunction

    // Model update on every edge, reset asynchronously like the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = RESET_PC; m_inst = 32'h0; m_a = 32'h0; m_t = 0; m_hit = 1'b0;
            for (int i = 0; i < LINES; i++) c_valid[i] = 1'b0;
        end else if (branch_i) begin
            m_pc = branch_target_i; m_t = 0; m_hit = 1'b0;
        end else if (m_valid_now()) begin
            if (id_ready_i && !stall_i) begin
                m_pc = m_pc + 32'd4; m_t = 0; m_hit = 1'b0;
            end
        end else if (m_t == 0 && cache_has(m_pc)) begin
            m_hit = 1'b1; m_t = 1; m_inst = c_word[int'(m_pc[5:2])];
        end else begin
            m_t = m_t + 1;
            if (m_t <= 4) m_a = m_pc + 32'(m_t - 1);
            if (m_t == 5) begin
                m_inst = mem_word(m_pc);
                c_valid[int'(m_pc[5:2])] = 1'b1;
                c_pc[int'(m_pc[5:2])] = m_pc;
                c_word[int'(m_pc[5:2])] = m_inst;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin : cmp
        bit ev;
        bit er;
        ev = m_valid_now();
        er = !m_hit && (m_t >= 1) && (m_t <= 4);
        check("pc", pc_o, m_pc);
        check("valid", 32'(inst_valid_o), 32'(ev));
        check("req", 32'(mem_req_o), 32'(er));
        check("addr", mem_a_o, m_a);
        if (ev || !rst) check("inst", inst_o, m_inst);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(output int n, output logic req1);
        n = 0;
        req1 = 1'b0;
        do begin
            cyc();
            n++;
            if (n == 1) req1 = mem_req_o;
        end while (!inst_valid_o && n < 40);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          n;
        logic        req1;
        logic [31:0] t;
        logic [31:0] wrap_word;

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'h20; mem[7] = 8'h00;
        mem[9'h40] = 8'hEF; mem[9'h41] = 8'hBE; mem[9'h42] = 8'hAD; mem[9'h43] = 8'hDE;

        // T1 reset
        rst = 1'b0;
        repeat (3) cyc();
        check("t1_pc", pc_o, RESET_PC);
        check("t1_inst", inst_o, 32'h0);
        check("t1_valid", 32'(inst_valid_o), 32'h0);
        check("t1_addr", mem_a_o, 32'h0);
        check("t1_req", 32'(mem_req_o), 32'h0);

        // T2 straight-line fetch
        rst = 1'b1; id_ready_i = 1'b1; stall_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t2_req", 32'(mem_req_o), 32'h1);
            check("t2_addr", mem_a_o, 32'(k));
            check("t2_early_valid", 32'(inst_valid_o), 32'h0);
        end
        cyc();
        check("t2_valid0", 32'(inst_valid_o), 32'h1);
        check("t2_inst0", inst_o, 32'h00100013);
        check("t2_pc0", pc_o, 32'h0);

        // T3 stall in HOLD
        stall_i = 1'b1;
        repeat (4) begin
            cyc();
            check("t3_pc", pc_o, 32'h0);
            check("t3_inst", inst_o, 32'h00100013);
            check("t3_valid", 32'(inst_valid_o), 32'h1);
            check("t3_req", 32'(mem_req_o), 32'h0);
        end
        stall_i = 1'b0;
        cyc();
        check("t3_accept_pc", pc_o, 32'h4);
        check("t3_accept_valid", 32'(inst_valid_o), 32'h0);
        wait_valid(n, req1);
        check("t2_latency1", 32'(n), 32'd5);
        check("t2_inst1", inst_o, 32'h00200093);
        check("t2_pc1", pc_o, 32'h4);
        cyc();
        check("t2_accept_pc", pc_o, 32'h8);
        wait_valid(n, req1);
        check("t2_latency2", 32'(n), 32'd5);
        check("t2_pc2", pc_o, 32'h8);

        // T5 branch and accept together
        branch_i = 1'b1; branch_target_i = 32'h100;
        cyc();
        check("t5_pc", pc_o, 32'h100);
        check("t5_valid", 32'(inst_valid_o), 32'h0);
        branch_i = 1'b0;

        // T4 branch mid-fetch at cnt=2
        cyc();
        cyc();
        branch_i = 1'b1; branch_target_i = 32'h40;
        cyc();
        check("t4_pc", pc_o, 32'h40);
        check("t4_valid", 32'(inst_valid_o), 32'h0);
        check("t4_req", 32'(mem_req_o), 32'h0);
        branch_i = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
            if (n == 1) begin
                check("t4_addr", mem_a_o, 32'h40);
                check("t4_req_on", 32'(mem_req_o), 32'h1);
            end
        end while (!inst_valid_o && n < 40);
        check("t4_latency", 32'(n), 32'd5);
        check("t4_inst", inst_o, 32'hDEADBEEF);

        // T6 loop 0x0 -> 0x4 -> branch 0x0, twice
        for (int pass = 0; pass < 2; pass++) begin
            branch_i = 1'b1; branch_target_i = 32'h0;
            cyc();
            branch_i = 1'b0;
            wait_valid(n, req1);
            if (pass == 1) begin
                check("t6_lat0", 32'(n), CACHE_ON ? 32'd1 : 32'd5);
                check("t6_req0", 32'(req1), CACHE_ON ? 32'd0 : 32'd1);
            end
            check("t6_inst0", inst_o, 32'h00100013);
            cyc();
            wait_valid(n, req1);
            check("t6_lat4", 32'(n), CACHE_ON ? 32'd1 : 32'd5);
            check("t6_inst4", inst_o, 32'h00200093);
        end

        // PC wrap at the top of the address space
        wrap_word = mem_word(32'hFFFFFFFC);
        branch_i = 1'b1; branch_target_i = 32'hFFFFFFFC;
        cyc();
        branch_i = 1'b0;
        wait_valid(n, req1);
        check("wrap_inst", inst_o, wrap_word);
        check("wrap_pc", pc_o, 32'hFFFFFFFC);
        cyc();
        check("wrap_next_pc", pc_o, 32'h0);

        // Random phase
        for (int c = 0; c < 4000; c++) begin
            int r;
            int sel;
            r = $urandom_range(0, 999);
            rst = (r >= 3);
            branch_i = (r >= 3) && (r < 60);
            id_ready_i = ($urandom_range(0, 3) != 0);
            stall_i = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: t = 32'($urandom_range(0, 3)) * 32'h4;
                3, 4:    t = 32'h40 + 32'($urandom_range(0, 3)) * 32'h4;
                5, 6:    t = 32'($urandom_range(0, 127)) * 32'h4;
                7:       t = 32'($urandom_range(0, 511));
                8:       t = 32'hFFFFFFFC;
                default: t = 32'hFFFFFFF8;
            endcase
            branch_target_i = t;
            cyc();
        end
        rst = 1'b1; branch_i = 1'b0; id_ready_i = 1'b1; stall_i = 1'b0;
        repeat (12) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
